// File: rtl/riscv_pkg.sv
// Shared loader definitions: FSM state encoding and word geometry.
package riscv_pkg;

    typedef enum logic [2:0] {
        LdIdle  = 3'd0,
        LdLen   = 3'd1,
        LdData  = 3'd2,
        LdFlush = 3'd3,
        LdDone  = 3'd4,
        LdErr   = 3'd5
    } loader_state_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream input and instruction-memory word write port of the loader.
interface imem_loader_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 8
);
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_ready;
    logic                     WE;
    logic [ADDRESS_WIDTH-1:0] WA;
    logic [31:0]              WD;
    logic [3:0]               WBE;

    // master: the loader (consumes the stream, drives memory writes)
    modport master (
        input  in_valid, in_data,
        output in_ready, WE, WA, WD, WBE
    );

    // slave: the environment (stream source and memory)
    modport slave (
        output in_valid, in_data,
        input  in_ready, WE, WA, WD, WBE
    );
endinterface

// File: rtl/byte_packer.sv
// Big-endian lane demux and word/byte-enable accumulator for the loader.
module byte_packer
    import riscv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    emit,
    input  logic [1:0]              lane,
    input  logic [7:0]              data,
    output logic [8*WORD_BYTES-1:0] word,
    output logic [WORD_BYTES-1:0]   be
);

    logic [8*WORD_BYTES-1:0] word_q;
    logic [WORD_BYTES-1:0]   be_q;

    // word/be include the byte being pushed this cycle, so the top can register them on emit
    always_comb begin
        word = word_q;
        be   = be_q;
        if (push) begin
            unique case (lane)
                2'd0: begin word[31:24] = data; be[3] = 1'b1; end
                2'd1: begin word[23:16] = data; be[2] = 1'b1; end
                2'd2: begin word[15:8]  = data; be[1] = 1'b1; end
                2'd3: begin word[7:0]   = data; be[0] = 1'b1; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            be_q   <= '0;
        end else if (clear || (push && emit)) begin
            word_q <= '0;
            be_q   <= '0;
        end else if (push) begin
            word_q <= word;
            be_q   <= be;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream to registered word writes,
// holding the CPU in reset until the image is complete.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned MEM_BYTES     = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold
);

    localparam logic [2:0] StIdle  = LdIdle;
    localparam logic [2:0] StLen   = LdLen;
    localparam logic [2:0] StData  = LdData;
    localparam logic [2:0] StFlush = LdFlush;
    localparam logic [2:0] StDone  = LdDone;
    localparam logic [2:0] StErr   = LdErr;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] hdr_len;
    logic        hs, last_byte;

    logic        pk_clear, pk_push, pk_emit;
    logic [31:0] pk_word;
    logic [3:0]  pk_be;

    logic                     in_ready_q;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] wa_q;
    logic [31:0]              wd_q;
    logic [3:0]               wbe_q;
    logic                     busy_q, done_q, error_q, cpu_hold_q;

    assign hs        = bus.in_valid & in_ready_q;
    assign hdr_len   = {len_q[23:0], bus.in_data[7:0]};
    assign last_byte = (cnt_q + 32'd1) == len_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        pk_clear = 1'b0;
        pk_push  = 1'b0;
        pk_emit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d    = '0;
                len_d    = '0;
                pk_clear = 1'b1;
                if (start) state_d = StLen;
            end
            StLen: begin
                if (hs) begin
                    len_d = hdr_len;
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_d = '0;
                        if (hdr_len == 32'd0)           state_d = StDone;
                        else if (hdr_len > MEM_BYTES)   state_d = StErr;
                        else                            state_d = StData;
                    end
                end
            end
            StData: begin
                if (hs) begin
                    pk_push = 1'b1;
                    pk_emit = (cnt_q[1:0] == 2'd3) || last_byte;
                    cnt_d   = cnt_q + 32'd1;
                    if (last_byte) state_d = StFlush;
                end
            end
            StFlush: state_d = StDone;
            StDone, StErr: begin
                if (start) begin
                    state_d  = StLen;
                    cnt_d    = '0;
                    len_d    = '0;
                    pk_clear = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    byte_packer u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pk_clear),
        .push  (pk_push),
        .emit  (pk_emit),
        .lane  (cnt_q[1:0]),
        .data  (bus.in_data[7:0]),
        .word  (pk_word),
        .be    (pk_be)
    );

    // Status and in_ready are registered from the next state, so nothing is combinational
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            len_q      <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            wbe_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            in_ready_q <= (state_d == StLen) || (state_d == StData);
            we_q       <= pk_emit;
            if (pk_emit) begin
                wa_q  <= ADDRESS_WIDTH'({cnt_q[31:2], 2'b00});
                wd_q  <= pk_word;
                wbe_q <= pk_be;
            end
            busy_q     <= (state_d == StLen) || (state_d == StData) || (state_d == StFlush);
            done_q     <= state_d == StDone;
            error_q    <= state_d == StErr;
            cpu_hold_q <= state_d != StDone;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.WE       = we_q;
    assign bus.WA       = wa_q;
    assign bus.WD       = wd_q;
    assign bus.WBE      = wbe_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = cpu_hold_q;

endmodule
